cv32e40p_rr_sched: RTL and testbench
====================================

CV32E40P_RR_SCHED -- requirements
Module: cv32e40p_rr_sched

Interface
REQ-001 Parameter NUM_REQ, default 8, number of requesters sharing one resource; legal range 2..32.
REQ-002 Parameter IDX_W, default $clog2(NUM_REQ), width of the grant index.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  NUM_REQ  per-requester request level; bit n = requester n.
REQ-006 flush_i  input  1  abort current transaction, return to IDLE.
REQ-007 rsrc_ready_i  input  1  resource accepts issued transaction this cycle.
REQ-008 rsrc_done_i  input  1  resource finished the accepted transaction.
REQ-009 rsrc_valid_o  output  1  transaction presented to resource.
REQ-010 gnt_o  output  NUM_REQ  one-hot grant, registered.
REQ-011 gnt_idx_o  output  IDX_W  binary index of granted requester, registered.
REQ-012 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT; encoding free.
REQ-014 IDLE: if any req_i bit set and flush_i low, SHALL latch winner into gnt_o/gnt_idx_o and go to ISSUE next cycle; else stay.
REQ-015 Winner selection SHALL be round-robin: masked = req_i bits with index > ptr; winner = lowest set bit of masked if nonzero, else lowest set bit of req_i.
REQ-016 Lowest-set-bit search SHALL be done by two find-first-one instances (masked, unmasked), purely combinational, no extra latency.
REQ-017 ISSUE: rsrc_valid_o=1; on rsrc_ready_i=1 go to WAIT; else hold valid_o, gnt_o, gnt_idx_o stable.
REQ-018 WAIT: rsrc_valid_o=0; on rsrc_done_i=1 go to IDLE, ptr <= gnt_idx_o, gnt_o <= 0.
REQ-019 Grant latency: req_i asserted in IDLE at edge N -> gnt_o/rsrc_valid_o high after edge N+1 (1 cycle); minimum turnaround IDLE->ISSUE->WAIT->IDLE = 3 cycles per transaction.
REQ-020 Grant SHALL be latched: deassertion of the granted req_i bit in ISSUE or WAIT SHALL NOT change gnt_o or state.
REQ-021 req_i changes outside IDLE SHALL be ignored; arbitration only evaluated in IDLE.
REQ-022 rsrc_ready_i outside ISSUE and rsrc_done_i outside WAIT SHALL be ignored (no same-cycle ready+done shortcut).
REQ-023 flush_i=1 in any state SHALL force IDLE next cycle, gnt_o <= 0, ptr unchanged; flush_i wins over simultaneous rsrc_ready_i, rsrc_done_i or new request.
REQ-024 ptr SHALL be IDX_W bits; ptr = NUM_REQ-1 yields empty mask (full unmasked search, lowest index wins); no wrap logic beyond that.
REQ-025 gnt_o SHALL always be one-hot or zero; gnt_o nonzero iff state in {ISSUE, WAIT}.
REQ-026 busy_o SHALL equal (state != IDLE), combinational from state register.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, gnt_o=0, gnt_idx_o=0, ptr=NUM_REQ-1, rsrc_valid_o=0, busy_o=0.
REQ-028 Reset asserted mid-transaction SHALL abandon it; first arbitration after release SHALL pick lowest set req_i bit.
REQ-029 No output SHALL depend on req_i before first clock edge after reset release.

Verification (NUM_REQ=8)
REQ-030 After reset, req_i=8'b1010_0100, ready/done 1 cycle after each step -> grants in order idx 2, 5, 7, 2; gnt_o=8'h04,8'h20,8'h80,8'h04.
REQ-031 req_i=8'hFF held constant -> idx sequence 0,1,...,7,0; each grant exactly 3 cycles with ready and done tied high.
REQ-032 Grant idx 3 issued, rsrc_ready_i held low 5 cycles, req_i[3] dropped meanwhile -> rsrc_valid_o, gnt_o=8'h08 stable all 5 cycles, WAIT on ready.
REQ-033 In WAIT for idx 4, flush_i=1 and rsrc_done_i=1 same cycle -> IDLE next cycle, gnt_o=0, ptr stays at previous value (next grant with req_i=8'h30 is idx 4, not 5).
REQ-034 rst_n pulsed low asynchronously in ISSUE -> outputs zero before next edge; after release with req_i=8'h81 grant idx 0.
REQ-035 Assertion bench: gnt_o onehot0 every cycle; rsrc_valid_o implies state ISSUE; gnt_o stable while busy_o and no flush.

Source files
------------

// File: rtl/cv32e40p_rr_sched_if.sv
// Scheduler handshake bundle: requester levels, flush, resource handshake
// and the registered grant outputs. The requester/resource side uses
// master; the scheduler itself uses slave.
interface cv32e40p_rr_sched_if #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0] req_i;
    logic               flush_i;
    logic               rsrc_ready_i;
    logic               rsrc_done_i;
    logic               rsrc_valid_o;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               busy_o;

    modport master (
        output req_i, flush_i, rsrc_ready_i, rsrc_done_i,
        input  rsrc_valid_o, gnt_o, gnt_idx_o, busy_o
    );

    modport slave (
        input  req_i, flush_i, rsrc_ready_i, rsrc_done_i,
        output rsrc_valid_o, gnt_o, gnt_idx_o, busy_o
    );
endinterface

// File: rtl/cv32e40p_rr_sched.sv
// Round-robin scheduler granting one of NUM_REQ requesters access to a
// single resource. One transaction at a time: IDLE arbitrates, ISSUE
// presents the transaction until accepted, WAIT holds the grant until the
// resource reports completion. flush_i aborts from any state.

// Find-first-one: index of the lowest set bit, purely combinational.
module cv32e40p_rr_sched_ffo #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);
    // Scan upward, keep only the first hit.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_vec[i] && !o_found) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

module cv32e40p_rr_sched #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cv32e40p_rr_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;

    logic [NUM_REQ-1:0] w_masked;
    logic [IDX_W-1:0]   w_idx_masked;
    logic [IDX_W-1:0]   w_idx_unmasked;
    logic               w_any_masked;
    logic               w_any_unmasked;
    logic [IDX_W-1:0]   w_winner;

    // Requests strictly above the last served index get first pick.
    always_comb begin
        w_masked = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            w_masked[n] = bus.req_i[n] && (n > 32'(r_ptr));
        end
    end

    cv32e40p_rr_sched_ffo #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_ffo_masked (
        .i_vec   (w_masked),
        .o_idx   (w_idx_masked),
        .o_found (w_any_masked)
    );

    cv32e40p_rr_sched_ffo #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_ffo_unmasked (
        .i_vec   (bus.req_i),
        .o_idx   (w_idx_unmasked),
        .o_found (w_any_unmasked)
    );

    assign w_winner = w_any_masked ? w_idx_masked : w_idx_unmasked;

    // Next state, grant and pointer; flush overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        if (bus.flush_i) begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_unmasked) begin
                        w_state_nxt = ST_ISSUE;
                        w_gnt_nxt   = NUM_REQ'(1) << w_winner;
                        w_idx_nxt   = w_winner;
                    end
                end
                ST_ISSUE: begin
                    if (bus.rsrc_ready_i) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.rsrc_done_i) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = r_idx;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.rsrc_valid_o = (r_state == ST_ISSUE);
    assign bus.busy_o       = (r_state != ST_IDLE);
    assign bus.gnt_o        = r_gnt;
    assign bus.gnt_idx_o    = r_idx;
endmodule

// File: tb/tb_cv32e40p_rr_sched.sv
// Bench for cv32e40p_rr_sched (NUM_REQ=8): transaction-level reference
// model checked every cycle, directed scenarios with literal expectations,
// then randomized traffic with occasional flush and reset.
module tb_cv32e40p_rr_sched;
    localparam int N = 8;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cv32e40p_rr_sched_if #(.NUM_REQ(N), .IDX_W(W)) bus ();

    cv32e40p_rr_sched #(.NUM_REQ(N), .IDX_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: busy phase (0 idle, 1 offering, 2 awaiting completion),
    // current grantee and last completed grantee.
    int m_phase = 0;
    int m_idx   = 0;
    int m_ptr   = N - 1;
    int m_pick;

    int unsigned e030_idx[4] = '{2, 5, 7, 2};
    logic [7:0]  e030_gnt[4] = '{8'h04, 8'h20, 8'h80, 8'h04};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Circular search starting just after the last served requester.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model update on each edge, then compare shortly after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else if (bus.flush_i) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_pick = rr_pick(bus.req_i, m_ptr);
            if (m_pick >= 0) begin
                m_idx   = m_pick;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.rsrc_ready_i) m_phase = 2;
        end else begin
            if (bus.rsrc_done_i) begin
                m_phase = 0;
                m_ptr   = m_idx;
            end
        end
        #1;
        chk("mdl_gnt",   32'(bus.gnt_o),     (m_phase != 0) ? (32'd1 << m_idx) : 32'd0);
        chk("mdl_idx",   32'(bus.gnt_idx_o), 32'(m_idx));
        chk("mdl_valid", 32'(bus.rsrc_valid_o), 32'(m_phase == 1));
        chk("mdl_busy",  32'(bus.busy_o),    32'(m_phase != 0));
        chk("onehot0",   32'($onehot0(bus.gnt_o)), 32'd1);
    end

    task automatic idle_inputs();
        bus.req_i        = '0;
        bus.flush_i      = 1'b0;
        bus.rsrc_ready_i = 1'b0;
        bus.rsrc_done_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsrc_valid_o) break;
        end
        chk({name, "_arrive"}, 32'(bus.rsrc_valid_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
        end
        chk({name, "_idle"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int last;
        idle_inputs();
        do_reset();
        chk("rst_gnt",   32'(bus.gnt_o), 32'h0);
        chk("rst_idx",   32'(bus.gnt_idx_o), 32'h0);
        chk("rst_valid", 32'(bus.rsrc_valid_o), 32'h0);
        chk("rst_busy",  32'(bus.busy_o), 32'h0);

        // Rotating grants over a sparse request set.
        bus.req_i = 8'b1010_0100;
        bus.rsrc_ready_i = 1'b1;
        bus.rsrc_done_i  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_valid("r030");
            chk("r030_idx", 32'(bus.gnt_idx_o), 32'(e030_idx[t]));
            chk("r030_gnt", 32'(bus.gnt_o), 32'(e030_gnt[t]));
        end

        // All requesting: full rotation, three cycles per grant.
        do_reset();
        bus.req_i = 8'hFF;
        bus.rsrc_ready_i = 1'b1;
        bus.rsrc_done_i  = 1'b1;
        last = 0;
        for (int t = 0; t < 9; t++) begin
            wait_valid("r031");
            chk("r031_idx", 32'(bus.gnt_idx_o), 32'(t % 8));
            if (t > 0) chk("r031_period", 32'(cyc - last), 32'd3);
            last = cyc;
        end

        // Stalled issue with the granted request dropped.
        do_reset();
        bus.req_i = 8'h08;
        wait_valid("r032");
        bus.req_i = 8'h00;
        for (int t = 0; t < 5; t++) begin
            chk("r032_valid", 32'(bus.rsrc_valid_o), 32'd1);
            chk("r032_gnt",   32'(bus.gnt_o), 32'h08);
            @(negedge clk);
        end
        bus.rsrc_ready_i = 1'b1;
        @(negedge clk);
        bus.rsrc_ready_i = 1'b0;
        chk("r032_wvalid", 32'(bus.rsrc_valid_o), 32'd0);
        chk("r032_wbusy",  32'(bus.busy_o), 32'd1);
        chk("r032_wgnt",   32'(bus.gnt_o), 32'h08);
        bus.rsrc_done_i = 1'b1;
        @(negedge clk);
        bus.rsrc_done_i = 1'b0;
        chk("r032_end", 32'(bus.gnt_o), 32'h0);

        // Flush beats done in WAIT; pointer keeps the previous winner.
        do_reset();
        bus.req_i = 8'h02;
        bus.rsrc_ready_i = 1'b1;
        bus.rsrc_done_i  = 1'b1;
        wait_valid("r033a");
        bus.req_i = 8'h00;
        wait_idle("r033a");
        bus.req_i = 8'h10;
        bus.rsrc_done_i = 1'b0;
        wait_valid("r033b");
        @(negedge clk);
        chk("r033_wait_gnt",  32'(bus.gnt_o), 32'h10);
        chk("r033_wait_busy", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        bus.rsrc_done_i = 1'b1;
        bus.req_i = 8'h30;
        @(negedge clk);
        chk("r033_fl_gnt",  32'(bus.gnt_o), 32'h0);
        chk("r033_fl_busy", 32'(bus.busy_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.rsrc_done_i = 1'b0;
        bus.rsrc_ready_i = 1'b0;
        @(negedge clk);
        chk("r033_next_idx", 32'(bus.gnt_idx_o), 32'd4);
        chk("r033_next_gnt", 32'(bus.gnt_o), 32'h10);

        // Asynchronous reset in ISSUE.
        do_reset();
        bus.req_i = 8'h01;
        bus.rsrc_ready_i = 1'b1;
        bus.rsrc_done_i  = 1'b1;
        wait_valid("r034a");
        bus.req_i = 8'h00;
        wait_idle("r034a");
        bus.rsrc_ready_i = 1'b0;
        bus.rsrc_done_i  = 1'b0;
        bus.req_i = 8'h80;
        wait_valid("r034b");
        chk("r034_pre_idx", 32'(bus.gnt_idx_o), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("r034_rst_gnt",   32'(bus.gnt_o), 32'h0);
        chk("r034_rst_valid", 32'(bus.rsrc_valid_o), 32'd0);
        chk("r034_rst_busy",  32'(bus.busy_o), 32'd0);
        chk("r034_rst_idx",   32'(bus.gnt_idx_o), 32'd0);
        #1 rst_n = 1'b1;
        bus.req_i = 8'h81;
        #1;
        chk("r034_rel_gnt", 32'(bus.gnt_o), 32'h0);
        @(negedge clk);
        chk("r034_new_idx", 32'(bus.gnt_idx_o), 32'd0);
        chk("r034_new_gnt", 32'(bus.gnt_o), 32'h01);

        // Randomized traffic; the model process checks every cycle.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) bus.req_i = 8'($urandom);
                else                           bus.req_i = 8'($urandom & $urandom & $urandom);
            end
            bus.flush_i      = ($urandom_range(0, 15) == 0);
            bus.rsrc_ready_i = 1'($urandom_range(0, 1));
            bus.rsrc_done_i  = 1'($urandom_range(0, 1));
            rst_n            = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
